// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC with next-PC select and I/O stall sequencer
// Optional PC_ALIGN_CHECK_EN: misaligned targets redirect to TRAP_ADDR and pulse misalign_err.
module pc_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    parameter int                IO_WAIT     = 5,
    parameter int                LINE_OFFSET = 2,
    parameter logic [ADDR_W-1:0] TRAP_ADDR   = '0
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              stall,
    input  logic              input_flag,
    input  logic              output_flag,
    input  logic              insert,
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] addressOut,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [31:0]       linha,
    output logic              io_busy
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic              misalign_err
`endif
);

    localparam int                CNT_W     = (IO_WAIT < 1) ? 1 : $clog2(IO_WAIT + 1);
    localparam bit                SETTLE_EN = (IO_WAIT != 0);
    localparam logic [CNT_W-1:0]  CNT_LAST  = SETTLE_EN ? CNT_W'(IO_WAIT - 1) : '0;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IO_HOLD   = 2'd1,
        IO_SETTLE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        linha_q, linha_d;
    logic               io_busy_q, io_busy_d;
`ifdef PC_ALIGN_CHECK_EN
    logic               misalign_q, misalign_d;
`endif

    logic [ADDR_W-1:0]  next_pc;
    logic [ADDR_W-1:0]  load_pc;
    logic               update;
    logic               io_flag;

    // Word index plus offset, zero-extended or truncated to 32 bits.
    function automatic logic [31:0] line_of(input logic [ADDR_W-1:0] a);
        logic [ADDR_W+31:0] ext;
        ext = {32'd0, a >> 2};
        return ext[31:0] + 32'(LINE_OFFSET);
    endfunction

    assign io_flag  = input_flag | output_flag;
    assign pc_plus4 = addr_q + ADDR_W'(4);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            addr_q     <= RESET_ADDR;
            linha_q    <= line_of(RESET_ADDR);
            io_busy_q  <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            linha_q    <= linha_d;
            io_busy_q  <= io_busy_d;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (!stall) begin
            case (state_q)
                RUN: begin
                    if (io_flag && !insert) state_d = IO_HOLD;
                end
                IO_HOLD: begin
                    if (insert) state_d = SETTLE_EN ? IO_SETTLE : RUN;
                end
                IO_SETTLE: begin
                    if (cnt_q == CNT_LAST) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        case (pc_sel)
            2'b00:   next_pc = pc_plus4;
            2'b01:   next_pc = branch_target;
            2'b10:   next_pc = jump_target;
            default: next_pc = reg_target;
        endcase

        update = 1'b0;
        cnt_d  = cnt_q;
        if (!stall) begin
            case (state_q)
                RUN: begin
                    update = !(io_flag && !insert);
                end
                IO_HOLD: begin
                    if (insert) begin
                        update = !SETTLE_EN;
                        cnt_d  = '0;
                    end
                end
                IO_SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        update = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: cnt_d = '0;
            endcase
        end

        load_pc = next_pc;
`ifdef PC_ALIGN_CHECK_EN
        misalign_d = misalign_q;
        if (!stall) misalign_d = 1'b0;
        if (update && (next_pc[1:0] != 2'b00)) begin
            load_pc    = TRAP_ADDR;
            misalign_d = 1'b1;
        end
`endif

        addr_d    = addr_q;
        linha_d   = linha_q;
        io_busy_d = io_busy_q;
        if (!stall) io_busy_d = (state_d != RUN);
        if (update) begin
            addr_d  = load_pc;
            linha_d = line_of(load_pc);
        end
    end

    assign addressOut = addr_q;
    assign linha      = linha_q;
    assign io_busy    = io_busy_q;
`ifdef PC_ALIGN_CHECK_EN
    assign misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vector bench for pc_sequencer
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        input_flag = 1'b0;
    logic        output_flag = 1'b0;
    logic        insert = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [31:0] branch_target = '0;
    logic [31:0] jump_target = '0;
    logic [31:0] reg_target = '0;
    logic [31:0] addressOut;
    logic [31:0] pc_plus4;
    logic [31:0] linha;
    logic        io_busy;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    logic [1:0]  sel8 = 2'b00;
    logic [7:0]  jt8 = '0;
    logic [7:0]  addr8;
    logic [7:0]  plus4_8;
    logic [31:0] linha8;
    logic        busy8;
`ifdef PC_ALIGN_CHECK_EN
    logic        mis8;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    pc_sequencer u_dut (
        .CLK(CLK), .reset(reset), .stall(stall),
        .input_flag(input_flag), .output_flag(output_flag), .insert(insert),
        .pc_sel(pc_sel), .branch_target(branch_target),
        .jump_target(jump_target), .reg_target(reg_target),
        .addressOut(addressOut), .pc_plus4(pc_plus4),
        .linha(linha), .io_busy(io_busy)
`ifdef PC_ALIGN_CHECK_EN
        , .misalign_err(misalign_err)
`endif
    );

    pc_sequencer #(.ADDR_W(8)) u_dut8 (
        .CLK(CLK), .reset(reset), .stall(1'b0),
        .input_flag(1'b0), .output_flag(1'b0), .insert(1'b0),
        .pc_sel(sel8), .branch_target(8'h00),
        .jump_target(jt8), .reg_target(8'h00),
        .addressOut(addr8), .pc_plus4(plus4_8),
        .linha(linha8), .io_busy(busy8)
`ifdef PC_ALIGN_CHECK_EN
        , .misalign_err(mis8)
`endif
    );

    typedef struct {
        logic [1:0]  sel;
        logic        fin;
        logic        fout;
        logic        ins;
        logic        stl;
        logic [31:0] tgt;
        logic [31:0] exp_addr;
        logic [31:0] exp_line;
        logic        exp_busy;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic edge_step;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //          sel    in    out   ins   stl   tgt      addr     line  busy
        tbl[0]  = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'd4,   32'd3,  1'b0};
        tbl[1]  = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'd8,   32'd4,  1'b0};
        tbl[2]  = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'd12,  32'd5,  1'b0};
        tbl[3]  = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'd16,  32'd6,  1'b0};
        tbl[4]  = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40,  32'h40,  32'd18, 1'b0};
        tbl[5]  = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h100, 32'd66, 1'b0};
        tbl[6]  = '{2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8,   32'd8,   32'd4,  1'b0};
        tbl[7]  = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'd8,   32'd4,  1'b1};
        tbl[8]  = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'd8,   32'd4,  1'b1};
        tbl[9]  = '{2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'd8,   32'd4,  1'b1};
        tbl[10] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'd8,   32'd4,  1'b1};
        tbl[11] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'd8,   32'd4,  1'b1};
        tbl[12] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'd8,   32'd4,  1'b1};
        tbl[13] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'd8,   32'd4,  1'b1};
        tbl[14] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'd12,  32'd5,  1'b0};
        tbl[15] = '{2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'd16,  32'd6,  1'b0};
        tbl[16] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,   32'd16,  32'd6,  1'b0};
        tbl[17] = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20,  32'h20,  32'd10, 1'b0};
        tbl[18] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h24,  32'd11, 1'b0};

        edge_step();
        edge_step();
        chk("reset_addr", addressOut, 32'd0);
        chk("reset_linha", linha, 32'd2);
        chk("reset_busy", {31'd0, io_busy}, 32'd0);
`ifdef PC_ALIGN_CHECK_EN
        chk("reset_misalign", {31'd0, misalign_err}, 32'd0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            pc_sel        = tbl[i].sel;
            input_flag    = tbl[i].fin;
            output_flag   = tbl[i].fout;
            insert        = tbl[i].ins;
            stall         = tbl[i].stl;
            branch_target = tbl[i].tgt;
            jump_target   = tbl[i].tgt;
            reg_target    = tbl[i].tgt;
            edge_step();
            chk($sformatf("v%0d_addr", i), addressOut, tbl[i].exp_addr);
            chk($sformatf("v%0d_linha", i), linha, tbl[i].exp_line);
            chk($sformatf("v%0d_busy", i), {31'd0, io_busy}, {31'd0, tbl[i].exp_busy});
            chk($sformatf("v%0d_plus4", i), pc_plus4, tbl[i].exp_addr + 32'd4);
        end
        pc_sel = 2'd0; stall = 1'b0;

        // Stall for 3 edges inside IO_SETTLE stretches the hold by 3 edges.
        input_flag = 1'b1; insert = 1'b0;
        edge_step();
        chk("hold_busy", {31'd0, io_busy}, 32'd1);
        insert = 1'b1;
        edge_step();
        insert = 1'b0; input_flag = 1'b0;
        begin
            int n;
            n = 0;
            while (n < 30) begin
                stall = (n >= 1 && n < 4);
                edge_step();
                n++;
                if (addressOut != 32'h24) break;
            end
            stall = 1'b0;
            chk("stall_settle_edges", n, 32'd8);
            chk("stall_settle_addr", addressOut, 32'h28);
            chk("stall_settle_busy", {31'd0, io_busy}, 32'd0);
        end

        // Asynchronous reset in the middle of IO_SETTLE.
        output_flag = 1'b1; insert = 1'b0;
        edge_step();
        insert = 1'b1;
        edge_step();
        insert = 1'b0; output_flag = 1'b0;
        edge_step();
        edge_step();
        chk("pre_reset_busy", {31'd0, io_busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_addr", addressOut, 32'd0);
        chk("async_reset_linha", linha, 32'd2);
        chk("async_reset_busy", {31'd0, io_busy}, 32'd0);
        #1 reset = 1'b0;
        edge_step();
        chk("post_reset_addr", addressOut, 32'd4);
        chk("post_reset_busy", {31'd0, io_busy}, 32'd0);

        // 8-bit PC wraps from 0xFC to 0x00.
        sel8 = 2'd2; jt8 = 8'hFC;
        edge_step();
        chk("w8_addr_fc", {24'd0, addr8}, 32'hFC);
        chk("w8_linha_fc", linha8, 32'd65);
        chk("w8_plus4_wrap", {24'd0, plus4_8}, 32'h0);
        sel8 = 2'd0;
        edge_step();
        chk("w8_addr_wrap", {24'd0, addr8}, 32'h0);
        chk("w8_linha_wrap", linha8, 32'd2);

`ifdef PC_ALIGN_CHECK_EN
        pc_sel = 2'd2; jump_target = 32'h42;
        edge_step();
        chk("trap_addr", addressOut, 32'd0);
        chk("trap_linha", linha, 32'd2);
        chk("trap_err", {31'd0, misalign_err}, 32'd1);
        pc_sel = 2'd0;
        edge_step();
        chk("trap_after_addr", addressOut, 32'd4);
        chk("trap_after_err", {31'd0, misalign_err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
